tps_tick_gen: RTL

//  Turns the TPS setpoint and run/step controls from command_controller into single-cycle

---
 rtl/tps_tick_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/tps_tick_gen.sv
// Phase-accumulator tick generator: free-run or N-tick single-step,
// emitting one-cycle strobes at i_tps ticks per second of i_clk.
module tps_tick_gen #(
  parameter int unsigned REF_CLK_HZ = 50_000_000,
  parameter int unsigned TPS_W      = 32,
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [TPS_W-1:0]  i_tps,
  input  logic              i_en,
  input  logic              i_step,
  input  logic [STEP_W-1:0] i_step_n,
  input  logic              i_clr_count,
  output logic              o_tick,
  output logic              o_running,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_tick_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP
  } state_t;

  typedef logic [TPS_W:0]   acc_t;
  typedef logic [TPS_W+1:0] wide_t;

  localparam wide_t REF_V = wide_t'(REF_CLK_HZ);

  state_t            state;
  acc_t              acc;
  logic [STEP_W-1:0] remaining;

  wide_t tps_x;
  wide_t t_clamp;
  wide_t sum;
  logic  hit;
  logic  tick_set;
  acc_t  acc_nxt;

  // Clamp to the modulus so the accumulator can wrap at most once per cycle.
  always_comb begin
    tps_x    = wide_t'(i_tps);
    t_clamp  = (tps_x > REF_V) ? REF_V : tps_x;
    sum      = wide_t'(acc) + t_clamp;
    hit      = (sum >= REF_V);
    acc_nxt  = hit ? acc_t'(sum - REF_V) : acc_t'(sum);
    tick_set = (state != IDLE) && hit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      acc          <= '0;
      remaining    <= '0;
      o_tick       <= 1'b0;
      o_tick_count <= '0;
    end else begin
      o_tick <= tick_set;

      if (i_clr_count) begin
        o_tick_count <= '0;
      end else if (tick_set) begin
        o_tick_count <= o_tick_count + CNT_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (i_en) begin
            state <= RUN;
            acc   <= '0;
          end else if (i_step && (i_step_n != '0)) begin
            state     <= STEP;
            remaining <= i_step_n;
            acc       <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (!i_en) begin
            state <= IDLE;
          end
        end
        STEP: begin
          acc <= acc_nxt;
          if (i_en) begin
            state     <= RUN;
            remaining <= '0;
          end else if (hit) begin
            // Final tick and return to IDLE share one edge.
            if (remaining == STEP_W'(1)) begin
              state     <= IDLE;
              remaining <= '0;
            end else begin
              remaining <= remaining - STEP_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_running = (state == RUN);
  assign o_busy    = (state == STEP);

endmodule
